booth_complement_divider: RTL and testbench

- Sequential signed shift-and-subtract (restoring) divider; the inverse-operation counterpart to the team's shift-and-add multiplier datapath.
- Self-contained: datapath (remainder/quotient shift pair, divisor register, subtractor) plus control FSM behind a START/READY/DONE handshake.
- Divides two size-bit two's-complement operands, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit. Results are held until the next operation completes.

---
 rtl/booth_complement_divider_if.sv | 24 ++
 rtl/booth_complement_divider.sv | 143 ++++++++++++++
 tb/tb_booth_complement_divider.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/booth_complement_divider_if.sv
// Handshake and operand/result bundle for the signed restoring divider.
// Master drives the request side, slave returns results and status.
interface booth_complement_divider_if #(
  parameter int size = 8
);
  logic            START;
  logic [size-1:0] A;
  logic [size-1:0] B;
  logic [size-1:0] Q;
  logic [size-1:0] R;
  logic            READY;
  logic            DONE;
  logic            DIV_BY_ZERO;

  modport master (
    output START, A, B,
    input  Q, R, READY, DONE, DIV_BY_ZERO
  );

  modport slave (
    input  START, A, B,
    output Q, R, READY, DONE, DIV_BY_ZERO
  );
endinterface

// File: rtl/booth_complement_divider.sv
// Signed shift-and-subtract (restoring) divider, one quotient bit per clock.
// Magnitudes are divided unsigned; signs are applied in the FIX step.
module booth_complement_divider #(
  parameter int size = 8
) (
  input logic                   CLOCK,
  input logic                   RESET,
  booth_complement_divider_if.slave bus
);
  localparam int CW = $clog2(size + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(size);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    FINISH
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [size:0]   rem;
  logic [size-1:0] quo;
  logic [size-1:0] dvs;
  logic [CW-1:0]   cnt;
  logic            sign_q;
  logic            sign_r;
  logic            zf;
  logic [size-1:0] q_r;
  logic [size-1:0] r_r;
  logic            done_r;
  logic            dbz_r;

  logic [size-1:0] a_mag;
  logic [size-1:0] b_mag;
  logic [size:0]   rem_sh;
  logic [size-1:0] quo_sh;
  logic [size:0]   trial;

  assign bus.Q           = q_r;
  assign bus.R           = r_r;
  assign bus.DONE        = done_r;
  assign bus.DIV_BY_ZERO = dbz_r;
  assign bus.READY       = (state == IDLE);

  // Operand magnitudes and one restoring trial step
  always_comb begin
    a_mag  = bus.A;
    b_mag  = bus.B;
    if (bus.A[size-1]) a_mag = '0 - bus.A;
    if (bus.B[size-1]) b_mag = '0 - bus.B;
    rem_sh = {rem[size-1:0], quo[size-1]};
    quo_sh = {quo[size-2:0], 1'b0};
    trial  = rem_sh - {1'b0, dvs};
  end

  // Control state register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.START) begin
          if (bus.B == '0) state_n = FIX;
          else             state_n = ITER;
        end
      end
      ITER:   if (cnt == CNT_ONE) state_n = FIX;
      FIX:    state_n = FINISH;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and result hold
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      zf     <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.START) begin
            rem <= '0;
            cnt <= CNT_INIT;
            if (bus.B == '0) begin
              quo <= bus.A;
              dvs <= '0;
              zf  <= 1'b1;
            end else begin
              quo    <= a_mag;
              dvs    <= b_mag;
              sign_q <= bus.A[size-1] ^ bus.B[size-1];
              sign_r <= bus.A[size-1];
              zf     <= 1'b0;
            end
          end
        end
        ITER: begin
          cnt <= cnt - CNT_ONE;
          if (!trial[size]) begin
            rem <= trial;
            quo <= {quo_sh[size-1:1], 1'b1};
          end else begin
            rem <= rem_sh;
            quo <= quo_sh;
          end
        end
        FIX: begin
          done_r <= 1'b1;
          if (zf) begin
            q_r   <= '1;
            r_r   <= quo;
            dbz_r <= 1'b1;
          end else begin
            q_r   <= sign_q ? ('0 - quo) : quo;
            r_r   <= sign_r ? ('0 - rem[size-1:0])
                            : rem[size-1:0];
            dbz_r <= 1'b0;
          end
        end
        FINISH: ;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_complement_divider.sv
// Directed bench for the signed restoring divider.
// Expected quotients/remainders are hand-computed truncating division.
module tb_booth_complement_divider;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  booth_complement_divider_if #(.size(8)) bus ();

  booth_complement_divider #(.size(8)) dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and check latency, results and the handshake
  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eq, input logic [7:0] er,
                     input logic ez, input int lat);
    int n;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    chk("ready_lo", bus.READY, 0);
    n = 0;
    while (n < 30) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.DONE) break;
    end
    chk("latency", n, lat);
    chk("q", bus.Q, eq);
    chk("r", bus.R, er);
    chk("dbz", bus.DIV_BY_ZERO, ez);
    @(posedge clk);
    #1;
    chk("done_pulse", bus.DONE, 0);
    chk("ready_hi", bus.READY, 1);
    chk("q_hold", bus.Q, eq);
  endtask

  initial begin
    int pulses;
    logic [7:0] q_seen;
    logic [7:0] r_seen;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.START = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", bus.Q, 0);
    chk("rst_r", bus.R, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_dbz", bus.DIV_BY_ZERO, 0);
    chk("rst_ready", bus.READY, 1);
    @(negedge clk);
    rst = 1'b0;

    run(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 9);
    run(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 9);
    run(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 9);
    run(8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 9);
    run(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9);
    run(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 9);
    run(8'd3, 8'd5, 8'h00, 8'h03, 1'b0, 9);
    run(8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 1);
    run(8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 9);
    run(8'd127, 8'd10, 8'h0C, 8'h07, 1'b0, 9);

    // Second START during iteration must be ignored
    @(negedge clk);
    bus.A = 8'd100;
    bus.B = 8'd7;
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.A = 8'd1;
    bus.B = 8'd1;
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    bus.A = 8'd55;
    bus.B = 8'd3;
    pulses = 0;
    q_seen = '0;
    r_seen = '0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (bus.DONE) begin
        pulses++;
        q_seen = bus.Q;
        r_seen = bus.R;
      end
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_q", q_seen, 8'h0E);
    chk("ign_r", r_seen, 8'h02);
    chk("ign_ready", bus.READY, 1);

    // Asynchronous reset mid-operation
    @(negedge clk);
    bus.A = 8'd100;
    bus.B = 8'd7;
    bus.START = 1'b1;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_q", bus.Q, 0);
    chk("arst_r", bus.R, 0);
    chk("arst_done", bus.DONE, 0);
    chk("arst_ready", bus.READY, 1);
    #1;
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      if (bus.DONE) pulses++;
    end
    chk("arst_nodone", pulses, 0);
    run(8'd50, 8'd6, 8'h08, 8'h02, 1'b0, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
